// File: rtl/single_cycle_arbiter_rsp_router.sv
// Return-path router for the fixed-priority arbiter: remembers which requester
// won each issued grant and steers the in-order response stream back to it.
module single_cycle_arbiter_rsp_router #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N-1:0]                 gnt_i,
  input  logic                         issue_i,
  input  logic                         rsp_valid_i,
  input  logic [DW-1:0]                rsp_data_i,
  output logic                         rsp_ready_o,
  output logic [N-1:0]                 rsp_valid_o,
  output logic [DW-1:0]                rsp_data_o,
  input  logic [N-1:0]                 rsp_ready_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic [2:0]                   err_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] r_fifo [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_err;

  logic [IW-1:0] w_idx;
  logic          w_multi;
  logic [IW-1:0] w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_any_gnt;
  logic          w_push;
  logic          w_pop;
  logic          w_overflow;
  logic          w_stall;

  // Scan from the top so the lowest set grant bit wins.
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (gnt_i[i]) w_idx = IW'(i);
    end
  end

  assign w_multi    = (gnt_i & (gnt_i - N'(1))) != '0;
  assign w_any_gnt  = |gnt_i;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_push     = issue_i & w_any_gnt & ~w_full;
  assign w_overflow = issue_i & w_any_gnt & w_full;
  assign w_stall    = rsp_valid_i & w_empty;
  assign w_pop      = rsp_valid_i & rsp_ready_o;

  always_comb begin
    rsp_valid_o         = '0;
    rsp_valid_o[w_head] = rsp_valid_i & ~w_empty;
  end

  assign rsp_ready_o   = rsp_ready_i[w_head] & ~w_empty;
  assign rsp_data_o    = rsp_data_i;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

  // ID storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_err <= r_err | {w_stall, w_overflow, w_multi};
    end
  end

endmodule

// File: tb/tb_single_cycle_arbiter_rsp_router.sv
// Scoreboard bench for single_cycle_arbiter_rsp_router: expected owner IDs are
// queued on issue and consumed as responses are routed.
module tb_single_cycle_arbiter_rsp_router;

  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  gnt_i;
  logic          issue_i;
  logic          rsp_valid_i;
  logic [DW-1:0] rsp_data_i;
  logic          rsp_ready_o;
  logic [N-1:0]  rsp_valid_o;
  logic [DW-1:0] rsp_data_o;
  logic [N-1:0]  rsp_ready_i;
  logic          full_o;
  logic          empty_o;
  logic [3:0]    outstanding_o;
  logic [2:0]    err_o;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  logic [2:0] mErr = 3'b000;

  single_cycle_arbiter_rsp_router #(.N(N), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .gnt_i(gnt_i), .issue_i(issue_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_ready_o(rsp_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .full_o(full_o), .empty_o(empty_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowIdx(input logic [31:0] g);
    for (int i = 0; i < 32; i++) if (g[i]) return i;
    return 0;
  endfunction

  // One clock cycle: drive, check against the model at negedge, advance model.
  task automatic applyStimulus(input logic issue, input logic [31:0] gnt, input logic rvalid,
                               input logic [31:0] rdata, input logic [31:0] rready);
    logic mEmpty, mFull, push, pop, expReady;
    logic [31:0] expValid;
    int head;
    issue_i = issue; gnt_i = gnt; rsp_valid_i = rvalid; rsp_data_i = rdata; rsp_ready_i = rready;
    @(negedge clk);
    mEmpty   = (expQ.size() == 0);
    mFull    = (expQ.size() == DEPTH);
    head     = mEmpty ? 0 : expQ[0];
    expValid = (rvalid && !mEmpty) ? (32'd1 << head) : 32'd0;
    expReady = !mEmpty && rready[head];
    checkOutput("empty", 64'(empty_o), 64'(mEmpty));
    checkOutput("full", 64'(full_o), 64'(mFull));
    checkOutput("outstanding", 64'(outstanding_o), 64'(expQ.size()));
    checkOutput("err", 64'(err_o), 64'(mErr));
    checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(expValid));
    checkOutput("rsp_ready", 64'(rsp_ready_o), 64'(expReady));
    checkOutput("rsp_data", 64'(rsp_data_o), 64'(rdata));
    push = issue && (gnt != 0) && !mFull;
    pop  = rvalid && expReady;
    if (pop) void'(expQ.pop_front());
    if (push) expQ.push_back(lowIdx(gnt));
    mErr = mErr | {rvalid && mEmpty, issue && (gnt != 0) && mFull, $countones(gnt) > 1};
    @(posedge clk); #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic issueOne(input logic [31:0] gnt);
    applyStimulus(1'b1, gnt, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic returnOne(input logic [31:0] data);
    applyStimulus(1'b0, 32'd0, 1'b1, data, 32'hFFFF_FFFF);
  endtask

  task automatic resetModel();
    expQ.delete();
    mErr = 3'b000;
  endtask

  initial begin
    reset = 1'b0;
    issue_i = 1'b1; gnt_i = 32'h1; rsp_valid_i = 1'b1; rsp_data_i = 32'h55; rsp_ready_i = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_empty", 64'(empty_o), 64'd1);
      checkOutput("rst_full", 64'(full_o), 64'd0);
      checkOutput("rst_outstanding", 64'(outstanding_o), 64'd0);
      checkOutput("rst_err", 64'(err_o), 64'd0);
      checkOutput("rst_valid", 64'(rsp_valid_o), 64'd0);
      checkOutput("rst_ready", 64'(rsp_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    issue_i = 1'b0; gnt_i = '0; rsp_valid_i = 1'b0; rsp_ready_i = '0;
    reset = 1'b1;
    idle();

    // In-order issue and return
    issueOne(32'h4);
    issueOne(32'h1);
    issueOne(32'h8000_0000);
    returnOne(32'hA);
    returnOne(32'hB);
    returnOne(32'hC);
    idle();

    // Backpressure from requester 5
    issueOne(32'h20);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 32'd0, 1'b1, 32'h55, ~32'h20);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h55, 32'hFFFF_FFFF);
    idle();

    // Fill, overflow, then wrap the pointers
    for (int i = 0; i < 8; i++) issueOne(32'd1 << i);
    issueOne(32'h100);
    idle();
    for (int i = 0; i < 3; i++) returnOne(32'h100 + 32'(i));
    for (int i = 8; i < 11; i++) issueOne(32'd1 << i);
    for (int i = 0; i < 8; i++) returnOne(32'h200 + 32'(i));
    idle();

    // Simultaneous push and pop at occupancy two
    issueOne(32'd1 << 20);
    issueOne(32'd1 << 21);
    applyStimulus(1'b1, 32'd1 << 22, 1'b1, 32'h300, 32'hFFFF_FFFF);
    returnOne(32'h301);
    returnOne(32'h302);
    idle();

    // Multi-hot grant, then response while empty
    issueOne(32'h6);
    returnOne(32'h400);
    returnOne(32'h401);
    idle();

    // Asynchronous reset mid-cycle with four outstanding
    for (int i = 0; i < 4; i++) issueOne(32'd1 << (i + 12));
    rsp_valid_i = 1'b1; rsp_ready_i = '1; rsp_data_i = 32'h500;
    #2;
    checkOutput("pre_async_outstanding", 64'(outstanding_o), 64'd4);
    reset = 1'b0;
    #1;
    checkOutput("async_outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("async_empty", 64'(empty_o), 64'd1);
    checkOutput("async_err", 64'(err_o), 64'd0);
    checkOutput("async_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("async_ready", 64'(rsp_ready_o), 64'd0);
    resetModel();
    @(posedge clk); #1;
    reset = 1'b1;
    returnOne(32'h501);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_cycle_arbiter_rsp_router.md
Name: single_cycle_arbiter_rsp_router

Overview:
- Return-path companion to the single-cycle fixed-priority arbiter.
- Records which requester won each issued grant in an in-order ID FIFO.
- Steers the downstream in-order response stream back to the owning requester using per-requester valid/ready.
- Sits between the shared downstream resource and the N requesters, opposite the arbiter's request path.

Parameters:
- N, 32, number of requesters; equals the arbiter's N.
- DEPTH, 8, maximum outstanding transactions (ID FIFO entries); power of two, ≥2.
- DW, 32, response data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- gnt_i  input  N  one-hot grant from arbiter (bit i = requester i).
- issue_i  input  1  downstream accepted the granted transaction this cycle.
- rsp_valid_i  input  1  downstream response valid.
- rsp_data_i  input  DW  downstream response data.
- rsp_ready_o  output  1  response accepted by the routed requester.
- rsp_valid_o  output  N  per-requester response valid; at most one bit set.
- rsp_data_o  output  DW  response data, broadcast to all requesters.
- rsp_ready_i  input  N  per-requester response ready.
- full_o  output  1  ID FIFO holds DEPTH entries.
- empty_o  output  1  ID FIFO holds 0 entries.
- outstanding_o  output  $clog2(DEPTH+1)  current FIFO occupancy.
- err_o  output  3  sticky error flags, defined below.

Behaviour:
- Reset (reset=0, async): rd_ptr, wr_ptr and count are 0; err_o=3'b000; empty_o=1; full_o=0; outstanding_o=0. While reset=0: rsp_valid_o=0 and rsp_ready_o=0. FIFO contents are don't-care.
- Index encode: idx = position of the lowest set bit of gnt_i, width $clog2(N).
  - If gnt_i has more than one bit set, set err_o[0]; the lowest bit is still used.
- Push: push = issue_i & (gnt_i != 0) & ~full_o. On push, write idx at wr_ptr and increment wr_ptr (wraps mod DEPTH).
  - issue_i with gnt_i == 0: no push, no error.
  - issue_i with gnt_i != 0 while full_o=1: entry dropped, set err_o[1].
- Full blocks push even if a pop occurs in the same cycle. There is no write-through.
- Head: head = fifo[rd_ptr], valid only when empty_o=0.
- Routing (combinational, zero latency):
  - rsp_valid_o = rsp_valid_i & ~empty_o, shifted to bit head.
  - rsp_ready_o = rsp_ready_i[head] & ~empty_o.
  - rsp_data_o = rsp_data_i, unconditionally.
- Pop: pop = rsp_valid_i & rsp_ready_o. On pop, increment rd_ptr (wraps mod DEPTH).
  - The entry pushed in cycle t is first visible as head in cycle t+1. No bypass from empty.
- rsp_valid_i while empty_o=1: rsp_ready_o=0, response stalled (not consumed), set err_o[2].
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Count update: count += push - pop.
  - full_o = (count == DEPTH); empty_o = (count == 0); outstanding_o = count.
- Valid/ready rules:
  - rsp_valid_o[k] may deassert only after the transfer, or when rsp_valid_i drops.
  - Data is not held by this block; downstream holds rsp_data_i stable while rsp_valid_i=1 and not accepted.
- err_o bits are sticky until reset; they have no effect on datapath operation.
- Reset asserted mid-operation: all outstanding IDs are discarded immediately. After release, responses arriving for pre-reset transactions see empty_o=1 and flag err_o[2].

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release.
  - Response: empty_o=1, full_o=0, outstanding_o=0, err_o=0, rsp_valid_o=0.
- Issue/return in order: issue gnt_i=0x4, then 0x1, then 0x80000000; return 3 responses with data 0xA, 0xB, 0xC, all rsp_ready_i=1.
  - Response: rsp_valid_o=0x4 with data 0xA, then 0x1 with 0xB, then 0x80000000 with 0xC; outstanding_o goes 3→0.
- Backpressure: one outstanding entry for requester 5, rsp_ready_i[5]=0 for 4 cycles, then 1.
  - Response: rsp_valid_o[5]=1 held 5 cycles; rsp_ready_o=0 then 1; single pop.
- Full and wrap: push 8 IDs (0..7), then a 9th issue with gnt_i=0x100.
  - Response: full_o=1, 9th dropped, err_o[1]=1.
  - Then pop 3, push 3 more (IDs 8..10): IDs return in order 3..10 across the pointer wrap.
- Simultaneous push/pop at count=2: push and pop in the same cycle.
  - Response: outstanding_o stays 2; next head is the correct ID.
- Errors and async reset:
  - gnt_i=0x6 issued: ID 1 recorded, err_o[0]=1.
  - rsp_valid_i while empty: err_o[2]=1, rsp_ready_o=0.
  - reset pulsed mid-cycle with 4 outstanding: outputs clear immediately without waiting for a clock edge.
